dqsw_training_ctrl: RTL and testbench

//  Sequences the DDR4 DQSW write-leveling training lane. It sweeps the lane's dynamic

---
 rtl/ddr_train_pkg.sv | 37 +++
 rtl/dqsw_tap_sampler.sv | 56 +++++
 rtl/dqsw_training_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dqsw_training_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_train_pkg.sv
// Shared types and default constants for the DDR training lane controllers.
package ddr_train_pkg;

  localparam int DEFAULT_NUM_TAPS      = 128;
  localparam int DEFAULT_TAP_W         = 7;
  localparam int DEFAULT_SETTLE_CYCLES = 8;
  localparam int DEFAULT_SAMPLE_COUNT  = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_PASS,
    S_ERR
  } dqsw_state_t;

  typedef enum logic [1:0] {
    TAP_LO,
    TAP_HI,
    TAP_MIX
  } tap_class_t;

  // A noisy window is never trusted as either side of the edge.
  function automatic tap_class_t classify_tap(input logic all_hi,
                                              input logic all_lo,
                                              input logic noisy);
    if (noisy)  return TAP_MIX;
    if (all_lo) return TAP_LO;
    if (all_hi) return TAP_HI;
    return TAP_MIX;
  endfunction

endpackage

// File: rtl/dqsw_tap_sampler.sv
// Accumulates one SAMPLE window: all-high, all-low and noisy verdicts over SAMPLE_COUNT cycles.
module dqsw_tap_sampler
  import ddr_train_pkg::*;
#(
  parameter int SAMPLE_COUNT = DEFAULT_SAMPLE_COUNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_window,
  input  logic [1:0] rx_data,
  input  logic       early,
  input  logic       late,
  output logic       all_hi,
  output logic       all_lo,
  output logic       noisy,
  output logic       window_done
);

  localparam int CNT_W = $clog2(SAMPLE_COUNT + 1);

  logic [CNT_W-1:0] count;
  logic             active;

  // start_window marks the first sample cycle; window_done rises the cycle after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      all_hi      <= 1'b0;
      all_lo      <= 1'b0;
      noisy       <= 1'b0;
      window_done <= 1'b0;
      active      <= 1'b0;
      count       <= '0;
    end else if (start_window) begin
      // NOTE: non-blocking (<=) so every accumulator update reads pre-clock values.
      all_hi      <= (rx_data == 2'b11);
      all_lo      <= (rx_data == 2'b00);
      noisy       <= early & late;
      count       <= CNT_W'(1);
      active      <= (SAMPLE_COUNT > 1);
      window_done <= (SAMPLE_COUNT == 1);
    end else begin
      window_done <= 1'b0;
      if (active) begin
        all_hi <= all_hi & (rx_data == 2'b11);
        all_lo <= all_lo & (rx_data == 2'b00);
        noisy  <= noisy | (early & late);
        count  <= count + CNT_W'(1);
        if (count == CNT_W'(SAMPLE_COUNT - 1)) begin
          active      <= 1'b0;
          window_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dqsw_training_ctrl.sv
// DQSW write-leveling sweep: steps the delay line tap by tap until the first clean low->high edge.
module dqsw_training_ctrl
  import ddr_train_pkg::*;
#(
  parameter int NUM_TAPS      = DEFAULT_NUM_TAPS,
  parameter int TAP_W         = DEFAULT_TAP_W,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int SAMPLE_COUNT  = DEFAULT_SAMPLE_COUNT
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] TAP_RESULT,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic [1:0]       RX_DATA
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  dqsw_state_t      state;
  logic [TAP_W-1:0] tap;
  logic [CNT_W-1:0] cnt;
  logic             seen_lo;
  logic             window_start;
  logic             all_hi;
  logic             all_lo;
  logic             noisy;
  logic             window_done;
  tap_class_t       tap_class;

  dqsw_tap_sampler #(
    .SAMPLE_COUNT (SAMPLE_COUNT)
  ) u_sampler (
    .clk          (FAB_CLK),
    .rst          (ARST),
    .start_window (window_start),
    .rx_data      (RX_DATA),
    .early        (EYE_MONITOR_EARLY),
    .late         (EYE_MONITOR_LATE),
    .all_hi       (all_hi),
    .all_lo       (all_lo),
    .noisy        (noisy),
    .window_done  (window_done)
  );

  assign tap_class = classify_tap(all_hi, all_lo, noisy);

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state                   <= S_IDLE;
      tap                     <= '0;
      cnt                     <= '0;
      seen_lo                 <= 1'b0;
      window_start            <= 1'b0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      FAIL                    <= 1'b0;
      TAP_RESULT              <= '0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
    end else begin
      // NOTE: every pulse defaults low here, so each one lasts exactly the cycle it is set for.
      window_start            <= 1'b0;
      DONE                    <= 1'b0;
      FAIL                    <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;

      case (state)
        S_IDLE: begin
          if (START) begin
            state                <= S_LOAD;
            BUSY                 <= 1'b1;
            DELAY_LINE_DIRECTION <= 1'b1;
            TAP_RESULT           <= '0;
            DELAY_LINE_LOAD      <= 1'b1;
          end
        end

        S_LOAD: begin
          tap                     <= '0;
          seen_lo                 <= 1'b0;
          EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
          state                   <= S_CLEAR;
        end

        S_CLEAR: begin
          cnt   <= '0;
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt          <= '0;
            window_start <= 1'b1;
            state        <= S_SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          if (cnt == CNT_W'(SAMPLE_COUNT - 1)) state <= S_EVAL;
          else                                 cnt   <= cnt + CNT_W'(1);
        end

        S_EVAL: begin
          if (window_done) begin
            if (tap_class == TAP_LO) seen_lo <= 1'b1;
            if (tap_class == TAP_HI && seen_lo) begin
              TAP_RESULT           <= tap;
              DONE                 <= 1'b1;
              BUSY                 <= 1'b0;
              DELAY_LINE_DIRECTION <= 1'b0;
              state                <= S_PASS;
            end else if (tap == TAP_W'(NUM_TAPS - 1)) begin
              TAP_RESULT           <= tap;
              FAIL                 <= 1'b1;
              BUSY                 <= 1'b0;
              DELAY_LINE_DIRECTION <= 1'b0;
              state                <= S_ERR;
            end else begin
              // Out-of-range is decided here so MOVE is a registered pulse in STEP.
              DELAY_LINE_MOVE <= ~DELAY_LINE_OUT_OF_RANGE;
              state           <= S_STEP;
            end
          end
        end

        S_STEP: begin
          if (DELAY_LINE_MOVE) begin
            tap                     <= tap + TAP_W'(1);
            EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
            state                   <= S_CLEAR;
          end else begin
            TAP_RESULT           <= tap;
            FAIL                 <= 1'b1;
            BUSY                 <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            state                <= S_ERR;
          end
        end

        S_PASS:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dqsw_training_ctrl.sv
// Self-checking bench: per-tap lane model driven from a scenario table, outcome predicted by a tap scan.
module tb_dqsw_training_ctrl;

  localparam int NT      = 128;
  localparam int PER_TAP = 15;
  localparam int TIMEOUT = NT * PER_TAP + 60;

  logic       FAB_CLK = 1'b0;
  logic       ARST;
  logic       START;
  logic       BUSY;
  logic       DONE;
  logic       FAIL;
  logic [6:0] TAP_RESULT;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic       EYE_MONITOR_EARLY;
  logic       EYE_MONITOR_LATE;
  logic [1:0] RX_DATA;

  dqsw_training_ctrl dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST                    (ARST),
    .START                   (START),
    .BUSY                    (BUSY),
    .DONE                    (DONE),
    .FAIL                    (FAIL),
    .TAP_RESULT              (TAP_RESULT),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
    .RX_DATA                 (RX_DATA)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int checks   = 0;
  int failures = 0;

  // Lane scenario: pat 0 = data 00, 1 = data 11, 2 = toggling 01/10; flg = {early, late}.
  int         pat [NT];
  logic [1:0] flg [NT];
  int         oor_from;
  int         cur_tap = 0;
  int         cyc     = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    int idx;
    idx = (cur_tap < NT) ? cur_tap : NT - 1;
    case (pat[idx])
      0:       RX_DATA = 2'b00;
      1:       RX_DATA = 2'b11;
      default: RX_DATA = (cyc % 2 == 0) ? 2'b01 : 2'b10;
    endcase
    EYE_MONITOR_EARLY       = flg[idx][1];
    EYE_MONITOR_LATE        = flg[idx][0];
    DELAY_LINE_OUT_OF_RANGE = (cur_tap >= oor_from);
  endtask

  task automatic set_ramp(input int edge_tap);
    for (int t = 0; t < NT; t++) begin
      pat[t] = (t < edge_tap) ? 0 : 1;
      flg[t] = 2'b00;
    end
    oor_from = NT;
  endtask

  // Scan the taps in order; the first clean high after any clean low wins.
  task automatic predict(output bit pass, output int tap);
    bit seen_low;
    bit lo;
    bit hi;
    seen_low = 1'b0;
    pass     = 1'b0;
    tap      = NT - 1;
    for (int t = 0; t < NT; t++) begin
      lo = (pat[t] == 0) && (flg[t] != 2'b11);
      hi = (pat[t] == 1) && (flg[t] != 2'b11);
      if (hi && seen_low) begin
        pass = 1'b1;
        tap  = t;
        return;
      end
      if (t == NT - 1 || t >= oor_from) begin
        tap = t;
        return;
      end
      if (lo) seen_low = 1'b1;
    end
  endtask

  task automatic run_sweep(input bit extra_starts, input int abort_tap,
                           output bit got_done, output bit got_fail,
                           output int loads, output int moves);
    int  cycle;
    int  last_pulse;
    int  since_move;
    int  pulses;
    bit  finished;
    cycle      = 0;
    last_pulse = 0;
    since_move = 0;
    finished   = 1'b0;
    got_done   = 1'b0;
    got_fail   = 1'b0;
    loads      = 0;
    moves      = 0;
    START      = 1'b1;
    while (!finished) begin
      @(negedge FAB_CLK);
      cycle++;
      cyc++;
      START  = extra_starts && (cycle == 20 || cycle == 60 || cycle == 200);
      pulses = int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS);
      if (pulses != 0) check("pulse_exclusive", pulses, 1);
      if (DELAY_LINE_LOAD) begin
        check("load_first", loads + moves, 0);
        check("busy_with_load", int'(BUSY), 1);
        loads++;
        cur_tap    = 0;
        last_pulse = cycle;
      end
      if (DELAY_LINE_MOVE) begin
        check("move_direction", int'(DELAY_LINE_DIRECTION), 1);
        check("tap_spacing", cycle - last_pulse, PER_TAP);
        moves++;
        cur_tap++;
        last_pulse = cycle;
        since_move = 0;
      end else begin
        since_move++;
      end
      if (DONE || FAIL) begin
        check("done_fail_exclusive", int'(DONE && FAIL), 0);
        check("busy_falls", int'(BUSY), 0);
        got_done = DONE;
        got_fail = FAIL;
        finished = 1'b1;
        if (extra_starts) START = 1'b1;
      end
      if (abort_tap >= 0 && moves == abort_tap && since_move == 3) finished = 1'b1;
      if (cycle > TIMEOUT) begin
        check("sweep_timeout", 0, 1);
        finished = 1'b1;
      end
      drive_inputs();
    end
  endtask

  task automatic run_case(input string name, input bit extra_starts);
    bit exp_pass;
    int exp_tap;
    bit got_done;
    bit got_fail;
    int loads;
    int moves;
    int late_loads;
    predict(exp_pass, exp_tap);
    run_sweep(extra_starts, -1, got_done, got_fail, loads, moves);
    check({name, "_done"}, int'(got_done), int'(exp_pass));
    check({name, "_fail"}, int'(got_fail), int'(!exp_pass));
    check({name, "_tap_result"}, int'(TAP_RESULT), exp_tap);
    check({name, "_moves"}, moves, exp_tap);
    check({name, "_loads"}, loads, 1);
    @(negedge FAB_CLK);
    cyc++;
    START = 1'b0;
    check({name, "_pulse_width"}, int'(DONE || FAIL), 0);
    if (extra_starts) begin
      late_loads = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge FAB_CLK);
        cyc++;
        if (DELAY_LINE_LOAD || BUSY) late_loads++;
      end
      check({name, "_no_restart"}, late_loads, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, int'({BUSY, DONE, FAIL, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                               DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}), 0);
    check({tag, "_tap_result"}, int'(TAP_RESULT), 0);
  endtask

  initial begin
    bit got_done;
    bit got_fail;
    int loads;
    int moves;
    int edge_tap;
    int r;

    ARST  = 1'b1;
    START = 1'b0;
    set_ramp(20);
    drive_inputs();
    repeat (3) @(negedge FAB_CLK);
    check_all_zero("reset");
    ARST = 1'b0;
    repeat (2) @(negedge FAB_CLK);

    set_ramp(20);
    run_case("edge20", 1'b0);

    for (int t = 0; t < NT; t++) pat[t] = 1;
    run_case("all_hi", 1'b0);

    set_ramp(30);
    flg[28] = 2'b11;
    flg[29] = 2'b11;
    pat[31] = 2;
    run_case("noisy_before_edge", 1'b0);
    flg[30] = 2'b11;
    run_case("noisy_edge", 1'b0);

    for (int t = 0; t < NT; t++) pat[t] = 0;
    for (int t = 0; t < NT; t++) flg[t] = 2'b00;
    oor_from = 10;
    run_case("out_of_range", 1'b0);

    set_ramp(20);
    run_sweep(1'b0, 5, got_done, got_fail, loads, moves);
    check("abort_point", moves, 5);
    ARST = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge FAB_CLK);
    ARST = 1'b0;
    @(negedge FAB_CLK);
    run_case("after_reset", 1'b0);

    set_ramp(20);
    run_case("start_glitch", 1'b1);

    for (int n = 0; n < 6; n++) begin
      edge_tap = $urandom_range(0, NT - 1);
      for (int t = 0; t < NT; t++) begin
        r = $urandom_range(0, 15);
        if (t < edge_tap) pat[t] = (r < 13) ? 0 : 2;
        else              pat[t] = (r < 12) ? 1 : ((r < 14) ? 2 : 0);
        flg[t] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      oor_from = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NT - 1) : NT;
      run_case("random", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
